// File: rtl/cvxif_result_queue.sv
// In-order result buffer between the coprocessor ALU and the CV-X-IF result port.
// Each entry waits at the head until its commit arrives: committed entries are offered, killed ones dropped.
module cvxif_result_queue #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned Depth       = 4,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned HartIdWidth = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [HartIdWidth-1:0]   alu_hartid_i,
  input  logic [IdWidth-1:0]       alu_id_i,
  input  logic [4:0]               alu_rd_i,
  input  logic                     alu_we_i,
  input  logic [XLEN-1:0]          alu_data_i,
  input  logic                     commit_valid_i,
  input  logic [IdWidth-1:0]       commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [HartIdWidth-1:0]   result_hartid_o,
  output logic [IdWidth-1:0]       result_id_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o,
  output logic [XLEN-1:0]          result_data_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned NumIds = 2 ** IdWidth;

  typedef struct packed {
    logic [HartIdWidth-1:0] hartid;
    logic [IdWidth-1:0]     id;
    logic [4:0]             rd;
    logic                   we;
    logic [XLEN-1:0]        data;
  } entry_t;

  entry_t            mem_q [Depth];
  entry_t            mem_d [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [NumIds-1:0] seen_q, seen_d;
  logic [NumIds-1:0] kill_q, kill_d;

  entry_t head;
  logic   not_empty;
  logic   head_seen;
  logic   head_kill;
  logic   deliver;
  logic   drop;
  logic   push;
  logic   pop;

  // Head decision depends only on registered state, so result_valid_o cannot glitch on result_ready_i.
  always_comb begin
    head      = mem_q[rptr_q];
    not_empty = (count_q != '0);
    head_seen = seen_q[head.id];
    head_kill = kill_q[head.id];
    deliver   = not_empty && head_seen && !head_kill;
    drop      = not_empty && head_seen && head_kill;
    push      = alu_valid_i && alu_ready_o;
    pop       = drop || (deliver && result_ready_i);
  end

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
    seen_d  = seen_q;
    kill_d  = kill_q;
    if (push) begin
      mem_d[wptr_q] = '{hartid: alu_hartid_i, id: alu_id_i, rd: alu_rd_i,
                        we: alu_we_i, data: alu_data_i};
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d          = rptr_q + PtrW'(1);
      seen_d[head.id] = 1'b0;
      kill_d[head.id] = 1'b0;
    end
    // Applied after the retire clear so a reused id's new commit survives.
    if (commit_valid_i) begin
      seen_d[commit_id_i] = 1'b1;
      kill_d[commit_id_i] = commit_kill_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      seen_q  <= '0;
      kill_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      seen_q  <= seen_d;
      kill_q  <= kill_d;
    end
  end

  // Payload storage needs no reset: it is only observable through a counted, committed head.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    alu_ready_o     = (count_q != CntW'(Depth));
    count_o         = count_q;
    result_valid_o  = deliver;
    result_hartid_o = deliver ? head.hartid : '0;
    result_id_o     = deliver ? head.id     : '0;
    result_rd_o     = deliver ? head.rd     : '0;
    result_we_o     = deliver ? head.we     : 1'b0;
    result_data_o   = deliver ? head.data   : '0;
  end

endmodule

// File: tb/tb_cvxif_result_queue.sv
// Bench for cvxif_result_queue: directed scenarios plus constrained-random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_cvxif_result_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [0:0]  alu_hartid_i;
  logic [3:0]  alu_id_i;
  logic [4:0]  alu_rd_i;
  logic        alu_we_i;
  logic [31:0] alu_data_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [0:0]  result_hartid_o;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [31:0] result_data_o;
  logic [2:0]  count_o;

  cvxif_result_queue #(.XLEN(32), .Depth(4), .IdWidth(4), .HartIdWidth(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_hartid_i(alu_hartid_i),
    .alu_id_i(alu_id_i), .alu_rd_i(alu_rd_i), .alu_we_i(alu_we_i), .alu_data_i(alu_data_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_hartid_o(result_hartid_o), .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .result_data_o(result_data_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int nvec = 0;
  int nerr = 0;

  // Reference model: results in push order, plus commit flags per id.
  typedef struct packed {
    logic [0:0]  hart;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  bit   mseen[16];
  bit   mkill[16];

  logic [47:0] dut_vec;
  assign dut_vec = {result_valid_o, result_hartid_o, result_id_o, result_rd_o,
                    result_we_o, result_data_o, count_o, alu_ready_o};

  function automatic logic [47:0] exp_vec();
    ent_t h = '0;
    logic v = 1'b0;
    int   n = mq.size();
    if (n > 0) begin
      h = mq[0];
      v = mseen[h.id] && !mkill[h.id];
    end
    if (!v) h = '0;
    return {v, h, 3'(n), 1'(n != DEPTH)};
  endfunction

  function automatic bit in_q(logic [3:0] id);
    foreach (mq[i]) if (mq[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit head_pops();
    if (mq.size() == 0) return 1'b0;
    return mseen[mq[0].id] && (mkill[mq[0].id] || result_ready_i);
  endfunction

  // Advance one clock; the model consumes the same inputs the DUT samples.
  task automatic tick();
    ent_t h;
    bit   pop, push;
    @(posedge clk_i);
    if (!rst_ni) begin
      mq.delete();
      for (int i = 0; i < 16; i++) begin mseen[i] = 1'b0; mkill[i] = 1'b0; end
    end else begin
      push = alu_valid_i && (mq.size() != DEPTH);
      pop  = head_pops();
      h    = (mq.size() > 0) ? mq[0] : '0;
      if (pop) begin
        mseen[h.id] = 1'b0;
        mkill[h.id] = 1'b0;
        void'(mq.pop_front());
      end
      if (commit_valid_i) begin
        mseen[commit_id_i] = 1'b1;
        mkill[commit_id_i] = commit_kill_i;
      end
      if (push) mq.push_back({alu_hartid_i, alu_id_i, alu_rd_i, alu_we_i, alu_data_i});
    end
    #1;
  endtask

  task automatic idle();
    alu_valid_i    = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic drive_push(input logic [3:0] id, input logic [4:0] rd, input logic we,
                            input logic [31:0] data, input logic [0:0] hart);
    alu_valid_i  = 1'b1;
    alu_id_i     = id;
    alu_rd_i     = rd;
    alu_we_i     = we;
    alu_data_i   = data;
    alu_hartid_i = hart;
  endtask

  task automatic drive_commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    result_ready_i = 1'b0;
    tick();
    tick();
    nvec++;
    if (dut_vec !== 48'd1) begin
      nerr++; $display("FAIL reset_state got %h exp %h", dut_vec, 48'd1);
    end
    nvec++;
    if (dut_vec !== exp_vec()) begin
      nerr++; $display("FAIL reset_model got %h exp %h", dut_vec, exp_vec());
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_commit_first();
    result_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) drive_commit(4'd3, 1'b0);
      if (c == 1) drive_push(4'd3, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0);
      tick();
      nvec++;
      if (dut_vec !== exp_vec()) begin
        nerr++; $display("FAIL commit_first c%0d got %h exp %h", c, dut_vec, exp_vec());
      end
      if (c == 1) begin
        nvec++;
        if ({result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o} !==
            {1'b1, 4'd3, 5'd5, 1'b1, 32'hDEADBEEF}) begin
          nerr++; $display("FAIL commit_first_result got v%b id%0d rd%0d data %h exp v1 id3 rd5 data deadbeef",
                           result_valid_o, result_id_o, result_rd_o, result_data_o);
        end
      end
      if (c == 2) begin
        nvec++;
        if (count_o !== 3'd0) begin
          nerr++; $display("FAIL commit_first_count got %0d exp 0", count_o);
        end
      end
    end
  endtask

  task automatic test_result_first();
    result_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) drive_push(4'd1, 5'd2, 1'b1, 32'h11, 1'b1);
      if (c == 6) drive_commit(4'd1, 1'b0);
      tick();
      nvec++;
      if (dut_vec !== exp_vec()) begin
        nerr++; $display("FAIL result_first c%0d got %h exp %h", c, dut_vec, exp_vec());
      end
      if (c >= 1 && c <= 5) begin
        nvec++;
        if (result_valid_o !== 1'b0) begin
          nerr++; $display("FAIL result_first_wait c%0d got valid %b exp 0", c, result_valid_o);
        end
      end
      if (c == 6) begin
        nvec++;
        if ({result_valid_o, result_id_o, result_data_o} !== {1'b1, 4'd1, 32'h11}) begin
          nerr++; $display("FAIL result_first_out got v%b id%0d data %h exp v1 id1 data 11",
                           result_valid_o, result_id_o, result_data_o);
        end
      end
    end
  endtask

  task automatic test_kill();
    result_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0 || c == 3) drive_push(4'd2, 5'd9, 1'b1, 32'h2222, 1'b0);
      if (c == 1) drive_commit(4'd2, 1'b1);
      if (c == 6) drive_commit(4'd2, 1'b0);
      tick();
      nvec++;
      if (dut_vec !== exp_vec()) begin
        nerr++; $display("FAIL kill c%0d got %h exp %h", c, dut_vec, exp_vec());
      end
      if (c <= 5) begin
        nvec++;
        if (result_valid_o !== 1'b0) begin
          nerr++; $display("FAIL kill_no_valid c%0d got valid %b exp 0", c, result_valid_o);
        end
      end
      if (c == 1 || c == 2) begin
        nvec++;
        if (count_o !== 3'(2 - c)) begin
          nerr++; $display("FAIL kill_count c%0d got %0d exp %0d", c, count_o, 2 - c);
        end
      end
      if (c == 6) begin
        nvec++;
        if ({result_valid_o, result_id_o} !== {1'b1, 4'd2}) begin
          nerr++; $display("FAIL kill_reuse got v%b id%0d exp v1 id2", result_valid_o, result_id_o);
        end
      end
    end
  endtask

  task automatic test_backpressure_full();
    logic [31:0] d0;
    d0 = $urandom;
    result_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      idle();
      result_ready_i = (c >= 6);
      if (c <= 3) begin
        drive_push(4'(c), 5'(c + 10), 1'b1, (c == 0) ? d0 : $urandom, 1'b0);
        drive_commit(4'(c), 1'b0);
      end
      if (c == 4) drive_push(4'd9, 5'd1, 1'b1, 32'h9, 1'b0);
      tick();
      nvec++;
      if (dut_vec !== exp_vec()) begin
        nerr++; $display("FAIL backpressure c%0d got %h exp %h", c, dut_vec, exp_vec());
      end
      if (c >= 3 && c <= 5) begin
        nvec++;
        if ({count_o, alu_ready_o, result_valid_o, result_id_o, result_data_o} !==
            {3'd4, 1'b0, 1'b1, 4'd0, d0}) begin
          nerr++; $display("FAIL full_hold c%0d got cnt%0d rdy%b v%b id%0d data %h exp cnt4 rdy0 v1 id0 data %h",
                           c, count_o, alu_ready_o, result_valid_o, result_id_o, result_data_o, d0);
        end
      end
      if (c >= 6 && c <= 8) begin
        nvec++;
        if ({result_valid_o, result_id_o} !== {1'b1, 4'(c - 5)}) begin
          nerr++; $display("FAIL drain_order c%0d got v%b id%0d exp v1 id%0d",
                           c, result_valid_o, result_id_o, c - 5);
        end
      end
      if (c == 9) begin
        nvec++;
        if ({count_o, alu_ready_o} !== {3'd0, 1'b1}) begin
          nerr++; $display("FAIL drain_empty got cnt%0d rdy%b exp cnt0 rdy1", count_o, alu_ready_o);
        end
      end
    end
  endtask

  task automatic test_order_wrap();
    result_ready_i = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 6; c++) begin
        idle();
        if (c == 0) drive_push(4'd4, 5'(r), 1'b0, $urandom, 1'b0);
        if (c == 1) begin
          drive_push(4'd5, 5'(r + 1), 1'b1, $urandom, 1'b1);
          drive_commit(4'd5, 1'b0);
        end
        if (c == 3) drive_commit(4'd4, 1'b0);
        tick();
        nvec++;
        if (dut_vec !== exp_vec()) begin
          nerr++; $display("FAIL order_wrap r%0d c%0d got %h exp %h", r, c, dut_vec, exp_vec());
        end
        if (c == 1 || c == 2) begin
          nvec++;
          if (result_valid_o !== 1'b0) begin
            nerr++; $display("FAIL no_overtake r%0d c%0d got valid %b exp 0", r, c, result_valid_o);
          end
        end
        if (c == 3 || c == 4) begin
          nvec++;
          if ({result_valid_o, result_id_o} !== {1'b1, 4'(c + 1)}) begin
            nerr++; $display("FAIL order r%0d c%0d got v%b id%0d exp v1 id%0d",
                             r, c, result_valid_o, result_id_o, c + 1);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 11; c++) begin
      idle();
      rst_ni = (c != 4);
      result_ready_i = (c >= 9);
      if (c == 0) drive_commit(4'd7, 1'b0);
      if (c >= 1 && c <= 3) begin
        drive_push(4'(c + 7), 5'(c), 1'b1, $urandom, 1'b0);
        drive_commit(4'(c + 7), 1'b0);
      end
      if (c == 5) drive_push(4'd7, 5'd7, 1'b1, 32'h7777, 1'b0);
      if (c == 8) drive_commit(4'd7, 1'b0);
      tick();
      nvec++;
      if (dut_vec !== exp_vec()) begin
        nerr++; $display("FAIL reset_mid c%0d got %h exp %h", c, dut_vec, exp_vec());
      end
      if (c == 3) begin
        nvec++;
        if ({count_o, result_valid_o} !== {3'd3, 1'b1}) begin
          nerr++; $display("FAIL reset_mid_fill got cnt%0d v%b exp cnt3 v1", count_o, result_valid_o);
        end
      end
      if (c == 4) begin
        nvec++;
        if (dut_vec !== 48'd1) begin
          nerr++; $display("FAIL reset_mid_clear got %h exp %h", dut_vec, 48'd1);
        end
      end
      if (c == 6 || c == 7) begin
        nvec++;
        if (result_valid_o !== 1'b0) begin
          nerr++; $display("FAIL stale_commit c%0d got valid %b exp 0", c, result_valid_o);
        end
      end
      if (c == 8) begin
        nvec++;
        if ({result_valid_o, result_id_o, result_data_o} !== {1'b1, 4'd7, 32'h7777}) begin
          nerr++; $display("FAIL recommit got v%b id%0d data %h exp v1 id7 data 7777",
                           result_valid_o, result_id_o, result_data_o);
        end
      end
    end
    rst_ni = 1'b1;
  endtask

  // Legal random traffic: ids are unique among outstanding instructions, each committed once.
  task automatic test_random();
    int  id;
    bool_t_dummy: begin end
    for (int c = 0; c < 2000; c++) begin
      idle();
      rst_ni = ($urandom_range(0, 399) != 0);
      result_ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6) begin
        id = $urandom_range(0, 15);
        if (!in_q(4'(id)))
          drive_push(4'(id), 5'($urandom), 1'($urandom), $urandom, 1'($urandom));
      end
      if ($urandom_range(0, 9) < 5) begin
        id = $urandom_range(0, 15);
        if (!mseen[id] || (head_pops() && mq[0].id == 4'(id)))
          drive_commit(4'(id), ($urandom_range(0, 3) == 0));
      end
      tick();
      nvec++;
      if (dut_vec !== exp_vec()) begin
        nerr++; $display("FAIL random c%0d got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    rst_ni = 1'b1;
    for (int c = 0; c < 100 && mq.size() != 0; c++) begin
      idle();
      result_ready_i = 1'b1;
      foreach (mq[i]) if (!mseen[mq[i].id] && !commit_valid_i) drive_commit(mq[i].id, 1'b0);
      tick();
      nvec++;
      if (dut_vec !== exp_vec()) begin
        nerr++; $display("FAIL random_drain c%0d got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    nvec++;
    if (count_o !== 3'd0 || mq.size() != 0) begin
      nerr++; $display("FAIL random_drain_timeout got cnt%0d model %0d exp 0", count_o, mq.size());
    end
  endtask

  initial begin
    rst_ni         = 1'b0;
    alu_valid_i    = 1'b0;
    alu_hartid_i   = '0;
    alu_id_i       = '0;
    alu_rd_i       = '0;
    alu_we_i       = 1'b0;
    alu_data_i     = '0;
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    result_ready_i = 1'b0;
    test_reset();
    test_commit_first();
    test_result_first();
    test_kill();
    test_backpressure_full();
    test_order_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cvxif_result_queue.md
Name: cvxif_result_queue

Overview:
- Result-side stage directly downstream of the coprocessor ALU in the CV-X-IF example coprocessor.
- Buffers ALU results in issue order and holds each one until the CPU commits it.
- Committed results go out on the CV-X-IF result interface with a valid/ready handshake.
- Killed results are discarded, so result_valid never precedes a commit and never ignores CPU backpressure.

Parameters:
- XLEN, 32, result data width.
- Depth, 4, number of result entries (power of two, >=2).
- IdWidth, 4, width of instruction id; the commit scoreboard has 2**IdWidth slots.
- HartIdWidth, 1, width of hart id.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- alu_valid_i  in  1  ALU result valid
- alu_ready_o  out  1  queue can accept an ALU result
- alu_hartid_i  in  HartIdWidth  hart id of the result
- alu_id_i  in  IdWidth  instruction id
- alu_rd_i  in  5  destination register
- alu_we_i  in  1  register write enable
- alu_data_i  in  XLEN  result data
- commit_valid_i  in  1  CV-X-IF commit valid
- commit_id_i  in  IdWidth  committed instruction id
- commit_kill_i  in  1  1 = instruction killed
- result_valid_o  out  1  CV-X-IF result valid
- result_ready_i  in  1  CPU accepts result
- result_hartid_o  out  HartIdWidth  result hart id
- result_id_o  out  IdWidth  result id
- result_rd_o  out  5  result rd
- result_we_o  out  1  result we
- result_data_o  out  XLEN  result data
- count_o  out  $clog2(Depth)+1  occupied entries

Behaviour:
Clocking and reset
- One clock. Reset is synchronous and active-low: clk_i, rst_ni.
- While rst_ni=0 at a rising edge: read/write pointers = 0, count = 0, all scoreboard slots cleared.
- All outputs read 0 except alu_ready_o, which is 1 after reset. This applies to reset mid-operation too; buffered results and pending commits are lost.

Push
- Push when alu_valid_i && alu_ready_o. The entry {hartid, id, rd, we, data} is written at the tail on that edge.
- alu_ready_o = (count != Depth), registered-state based. There is no push bypass when full, even if a pop happens the same cycle.

Commit scoreboard
- Per-id flags seen[id] and kill[id].
- On commit_valid_i: seen[commit_id_i] <= 1 and kill[commit_id_i] <= commit_kill_i, both visible from the next cycle.
- A commit may arrive before or after the matching result is pushed; both orders must work.

Head handling, combinational from registered state
- If empty, or !seen[head.id]: result_valid_o = 0 and the head waits.
- If seen && kill: the entry is dropped in one cycle. Pop, clear seen/kill[head.id], result_valid_o = 0.
- If seen && !kill: result_valid_o = 1 with the head fields. On result_ready_i = 1, pop and clear seen/kill[head.id].

Result handshake and ordering
- Once result_valid_o = 1, it and every result field stay stable until the handshake.
- Results leave strictly in push order. A later committed entry never overtakes an uncommitted head.

Latency and counting
- Minimum latency is 1 cycle: push at edge N with the commit already seen gives result_valid_o = 1 in cycle N+1.
- A commit in the same cycle as the push gives result_valid_o in cycle N+1 as well.
- Simultaneous push and pop/drop: count unchanged, pointers wrap modulo Depth.
- A commit arriving in the same cycle as a clear of the same id: the commit write wins. This covers id reuse.

Not supported
- Result accumulation per hart and multiple outstanding instructions with the same id are not supported. The issue side guarantees unique outstanding ids.

Test Plan:
- Commit first: commit id=3, no kill; next cycle push id=3 rd=5 data=0xDEADBEEF we=1 with result_ready_i=1 -> result_valid_o=1 one cycle after the push with id=3, rd=5, data=0xDEADBEEF; count returns to 0.
- Result first: push id=1 data=0x11, hold 5 cycles with no commit -> result_valid_o stays 0. Commit id=1 -> result_valid_o=1 on the next cycle.
- Kill: push id=2, commit id=2 kill=1 -> result_valid_o never asserts, entry dropped in 1 cycle, count 1->0, seen[2] cleared.
- Backpressure/full: result_ready_i=0, push ids 0..3 all committed -> count_o=4, alu_ready_o=0, result_valid_o=1 with id=0 stable. Assert ready for 4 cycles -> ids 0,1,2,3 delivered in order, alu_ready_o=1.
- Ordering and wrap: push id=4 (uncommitted) then id=5 (committed) -> no result. Commit id=4 -> id=4 then id=5 delivered. Repeat 10 times so the pointers wrap.
- Reset mid-operation: 3 entries buffered with result_valid_o=1, pull rst_ni low for 1 edge -> all outputs 0, count_o=0, alu_ready_o=1. An old commit does not resurrect a later push with the same id unless it is committed again.
